// File: rtl/cache_axi_master.sv
// cache_axi_master: turns single-line cache requests into one AXI-style read or write burst,
// with optional alignment rejection and a per-request bus-wait timeout.
module cache_axi_master #(
    parameter int TIMEOUT     = 1024,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wstrb,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_err,
    output logic [31:0]  readAddr_addr,
    output logic         readAddr_valid,
    input  logic         readAddr_ready,
    input  logic [127:0] readData_data,
    input  logic         readData_valid,
    output logic         readData_ready,
    output logic [31:0]  writeAddr_addr,
    output logic         writeAddr_valid,
    input  logic         writeAddr_ready,
    output logic [127:0] writeData_data,
    output logic [15:0]  writeData_strb,
    output logic         writeData_valid,
    input  logic         writeData_ready,
    input  logic [31:0]  writeResp_msg,
    input  logic         writeResp_valid,
    output logic         writeResp_ready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WSEND, WRESP, RESP} state_t;
    state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d, cnt_q, cnt_d;
    logic [127:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [15:0]  wstrb_q, wstrb_d;
    logic         write_q, write_d, err_q, err_d;
    logic         aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic         accept, aw_hs, w_hs, busy, expired;

    assign req_ready       = state_q == IDLE;
    assign accept          = req_valid && req_ready;
    assign readAddr_valid  = state_q == RADDR;
    assign readAddr_addr   = readAddr_valid ? addr_q : 32'd0;
    assign readData_ready  = state_q == RDATA;
    assign writeAddr_valid = state_q == WSEND && write_q && !aw_done_q;
    assign writeAddr_addr  = writeAddr_valid ? addr_q : 32'd0;
    assign writeData_valid = state_q == WSEND && write_q && !w_done_q;
    assign writeData_data  = writeData_valid ? wdata_q : 128'd0;
    assign writeData_strb  = writeData_valid ? wstrb_q : 16'd0;
    assign writeResp_ready = state_q == WRESP;
    assign resp_valid      = state_q == RESP;
    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;
    assign aw_hs           = writeAddr_valid && writeAddr_ready;
    assign w_hs            = writeData_valid && writeData_ready;
    assign busy            = state_q inside {RADDR, RDATA, WSEND, WRESP};
    // The counter hits TIMEOUT on the same edge that moves us to RESP.
    assign expired         = (TIMEOUT != 0) && busy && (cnt_q == 32'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = busy ? cnt_q + 32'd1 : cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                addr_d    = req_addr;
                wdata_d   = req_wdata;
                wstrb_d   = req_wstrb;
                write_d   = req_write;
                rdata_d   = 128'd0;
                cnt_d     = 32'd0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                err_d     = ALIGN_CHECK && (req_addr[3:0] != 4'd0);
                state_d   = err_d ? RESP : req_write ? WSEND : RADDR;
            end
            RADDR: state_d = readAddr_ready ? RDATA : RADDR;
            RDATA: if (readData_valid) begin
                rdata_d = readData_data;
                state_d = RESP;
            end
            WSEND: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                state_d   = (aw_done_d && w_done_d) ? WRESP : WSEND;
            end
            WRESP: if (writeResp_valid) begin
                err_d   = writeResp_msg != 32'd0;
                state_d = RESP;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (expired) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 128'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master: directed vectors against a small SRAM bus slave, plus skew, timeout,
// stray-response and mid-transaction reset sequences.
module tb_cache_axi_master;
    localparam logic [127:0] LINE1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clk = 1'b0, rst = 1'b1;
    logic         req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_wstrb = '0;
    logic         req_ready, resp_valid, resp_err;
    logic [127:0] resp_rdata;
    logic [31:0]  readAddr_addr, writeAddr_addr, writeResp_msg;
    logic         readAddr_valid, readData_valid, readData_ready;
    logic         writeAddr_valid, writeData_valid, writeResp_valid, writeResp_ready;
    logic [127:0] readData_data, writeData_data;
    logic [15:0]  writeData_strb;
    logic         ar_en = 1'b1, aw_en = 1'b1, w_en = 1'b1, stray_r = 1'b0, stray_b = 1'b0;
    logic [31:0]  b_msg = '0;

    logic [127:0] mem [0:255];
    logic         rv_q = 1'b0, bv_q = 1'b0, got_aw = 1'b0, got_w = 1'b0;
    logic [127:0] rd_q = '0, w_d = '0, eff_d;
    logic [31:0]  aw_a = '0, bm_q = '0, eff_a;
    logic [15:0]  w_s = '0, eff_s;
    logic         aw_hs_w, w_hs_w;
    int           aw_n = 0, w_n = 0, vcyc = 0, checks = 0, errors = 0;

    cache_axi_master #(.TIMEOUT(8), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(ar_en),
        .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(aw_en),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(w_en),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] init_line(input int i);
        return (i == 1) ? LINE1 : {4{32'hC0DE0000 | 32'(i)}};
    endfunction

    assign aw_hs_w         = writeAddr_valid && aw_en;
    assign w_hs_w          = writeData_valid && w_en;
    assign eff_a           = aw_hs_w ? writeAddr_addr : aw_a;
    assign eff_d           = w_hs_w ? writeData_data : w_d;
    assign eff_s           = w_hs_w ? writeData_strb : w_s;
    assign readData_valid  = rv_q | stray_r;
    assign readData_data   = rv_q ? rd_q : {4{32'hDEADBEEF}};
    assign writeResp_valid = bv_q | stray_b;
    assign writeResp_msg   = bv_q ? bm_q : 32'hFFFF_FFFF;

    // SRAM slave: R one cycle after AR, B one cycle after both AW and W.
    always @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0; bv_q <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= init_line(i);
        end else begin
            if (readAddr_valid && ar_en) begin rv_q <= 1'b1; rd_q <= mem[readAddr_addr[11:4]]; end
            else if (rv_q && readData_ready) rv_q <= 1'b0;
            if (aw_hs_w) begin got_aw <= 1'b1; aw_a <= writeAddr_addr; end
            if (w_hs_w) begin got_w <= 1'b1; w_d <= writeData_data; w_s <= writeData_strb; end
            if ((got_aw || aw_hs_w) && (got_w || w_hs_w)) begin
                got_aw <= 1'b0; got_w <= 1'b0; bv_q <= 1'b1; bm_q <= b_msg;
                for (int i = 0; i < 16; i++)
                    if (eff_s[i]) mem[eff_a[11:4]][8*i +: 8] <= eff_d[8*i +: 8];
            end else if (bv_q && writeResp_ready) bv_q <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (aw_hs_w) aw_n <= aw_n + 1;
        if (w_hs_w) w_n <= w_n + 1;
        if (readAddr_valid | writeAddr_valid | writeData_valid) vcyc <= vcyc + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns at the falling edge of the first cycle after acceptance.
    task automatic start_req(input logic wr, input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        chk("req_ready_before", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string nm, input int n0, input int lat, input int hold,
                             input logic [127:0] er, input logic ee);
        int n = n0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        chk({nm, "_resp_seen"}, resp_valid, 1);
        if (lat != 0) chk({nm, "_latency"}, n, lat);
        chk({nm, "_rdata"}, resp_rdata, er);
        chk({nm, "_err"}, resp_err, ee);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold"}, {resp_valid, resp_err, readAddr_valid, resp_rdata}, {1'b1, ee, 1'b0, er});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_back_idle"}, {req_ready, resp_valid}, 2'b10);
    endtask

    typedef struct {
        logic wr; logic [31:0] a; logic [127:0] d; logic [15:0] s; logic [31:0] bm;
        int lat; logic [127:0] er; logic ee;
    } vec_t;
    vec_t v[9];

    initial begin
        v[0] = '{1'b0, 32'h10, '0, '0, '0, 3, LINE1, 1'b0};
        v[1] = '{1'b1, 32'h20, {16{8'hA5}}, 16'h00FF, '0, 3, '0, 1'b0};
        v[2] = '{1'b0, 32'h20, '0, '0, '0, 3, {64'hC0DE0002_C0DE0002, {8{8'hA5}}}, 1'b0};
        v[3] = '{1'b0, 32'h24, '0, '0, '0, 1, '0, 1'b1};
        v[4] = '{1'b1, 32'h28, {16{8'h5A}}, 16'hFFFF, '0, 1, '0, 1'b1};
        v[5] = '{1'b1, 32'h40, 128'h01234567_89ABCDEF_02468ACE_13579BDF, 16'hFFFF, 32'h5, 3, '0, 1'b1};
        v[6] = '{1'b0, 32'h40, '0, '0, '0, 3, 128'h01234567_89ABCDEF_02468ACE_13579BDF, 1'b0};
        v[7] = '{1'b1, 32'h30, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'hF00F, '0, 3, '0, 1'b0};
        v[8] = '{1'b0, 32'h30, '0, '0, '0, 3, 128'hFFEEDDCC_C0DE0003_C0DE0003_33221100, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {req_ready, resp_valid, resp_err, readAddr_valid, readData_ready,
                           writeAddr_valid, writeData_valid, writeResp_ready}, 8'b1000_0000);
        chk("reset_data", {resp_rdata, readAddr_addr, writeAddr_addr, writeData_strb}, '0);

        stray_r = 1'b1; stray_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("stray_ignored", {readData_ready, writeResp_ready, req_ready, resp_valid}, 4'b0010);
        stray_r = 1'b0; stray_b = 1'b0;

        for (int i = 0; i < 9; i++) begin
            int vc0;
            vc0 = vcyc;
            b_msg = v[i].bm;
            start_req(v[i].wr, v[i].a, v[i].d, v[i].s);
            wait_resp($sformatf("vec%0d", i), 1, v[i].lat, 0, v[i].er, v[i].ee);
            if (v[i].a[3:0] != 4'd0) chk($sformatf("vec%0d_no_bus", i), vcyc - vc0, 0);
        end
        b_msg = '0;

        begin : skew
            int aw0, w0;
            aw0 = aw_n; w0 = w_n;
            w_en = 1'b0;
            start_req(1'b1, 32'h50, {8{16'hBEEF}}, 16'hFFFF);
            repeat (3) @(negedge clk);
            chk("skew_mid", {writeAddr_valid, writeData_valid, writeResp_ready}, 3'b010);
            w_en = 1'b1;
            @(negedge clk);
            chk("skew_wresp_entered", {writeAddr_valid, writeData_valid, writeResp_ready}, 3'b001);
            wait_resp("skew", 5, 0, 0, '0, 1'b0);
            chk("skew_hs_count", {aw_n - aw0, w_n - w0}, {32'd1, 32'd1});
        end
        start_req(1'b0, 32'h50, '0, '0);
        wait_resp("skew_readback", 1, 3, 0, {8{16'hBEEF}}, 1'b0);

        ar_en = 1'b0;
        start_req(1'b0, 32'h60, '0, '0);
        wait_resp("timeout", 1, 9, 5, '0, 1'b1);
        ar_en = 1'b1;

        aw_en = 1'b0; w_en = 1'b0;
        start_req(1'b1, 32'h70, {16{8'h11}}, 16'hFFFF);
        chk("wsend_active", {writeAddr_valid, writeData_valid}, 2'b11);
        rst = 1'b1;
        #1;
        chk("rst_immediate", {readAddr_valid, writeAddr_valid, writeData_valid, readData_ready,
                              writeResp_ready, resp_valid, req_ready}, 7'b0000001);
        @(negedge clk) rst = 1'b0;
        aw_en = 1'b1; w_en = 1'b1;
        start_req(1'b0, 32'h10, '0, '0);
        wait_resp("post_rst_read", 1, 3, 0, LINE1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_axi_master.md
CACHE_AXI_MASTER -- requirements
Module: cache_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the bus-wait cycle limit per request (0 disables the limit).
REQ-002 SHALL have parameter ALIGN_CHECK, default 1, meaning requests with addr[3:0]!=0 are rejected.
REQ-003 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-004 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  128  write line
- req_wstrb  in  16  byte enables, bit i selects wdata[8i+7:8i]
- resp_valid  out  1  response valid
- resp_ready  in  1  client accepts response
- resp_rdata  out  128  read line (0 for writes and errors)
- resp_err  out  1  error flag
- readAddr_addr  out  32  AR address
- readAddr_valid  out  1  AR valid
- readAddr_ready  in  1  AR ready
- readData_data  in  128  R data
- readData_valid  in  1  R valid
- readData_ready  out  1  R ready
- writeAddr_addr  out  32  AW address
- writeAddr_valid  out  1  AW valid
- writeAddr_ready  in  1  AW ready
- writeData_data  out  128  W data
- writeData_strb  out  16  W strobe
- writeData_valid  out  1  W valid
- writeData_ready  in  1  W ready
- writeResp_msg  in  32  B message (nonzero = error)
- writeResp_valid  in  1  B valid
- writeResp_ready  out  1  B ready

Function
REQ-005 SHALL use states IDLE, RADDR, RDATA, WSEND, WRESP, RESP.
REQ-006 SHALL drive req_ready=1 only in IDLE and SHALL accept a request on req_valid&&req_ready, capturing addr/wdata/wstrb/write.
REQ-007 On acceptance SHALL go IDLE->RESP with resp_err=1 when ALIGN_CHECK=1 and addr[3:0]!=0, with no bus activity.
REQ-008 SHALL otherwise go IDLE->RADDR for a read or IDLE->WSEND for a write.
REQ-009 In RADDR SHALL hold readAddr_valid=1 with stable address until readAddr_ready, then go to RDATA.
REQ-010 In RDATA SHALL drive readData_ready=1; on readData_valid SHALL capture readData_data into resp_rdata and go to RESP.
REQ-011 In WSEND SHALL assert writeAddr_valid and writeData_valid together; each SHALL deassert independently after its own handshake cycle; SHALL go to WRESP in the cycle after both handshakes are complete, same-cycle handshakes included.
REQ-012 In WRESP SHALL drive writeResp_ready=1; on writeResp_valid SHALL set resp_err=(writeResp_msg!=0) and go to RESP.
REQ-013 In RESP SHALL hold resp_valid=1 and keep resp_rdata/resp_err stable until resp_ready, then return to IDLE.
REQ-014 SHALL never have a read and a write outstanding together; at most one request is in flight.
REQ-015 Each bus valid output SHALL rise no earlier than the cycle after acceptance.
REQ-016 Minimum latency from acceptance to resp_valid SHALL be 3 cycles for a read and 3 cycles for a write (all readies high).
REQ-017 Timeout counter SHALL clear on acceptance and increment each cycle in RADDR/RDATA/WSEND/WRESP.
REQ-018 When the timeout counter reaches TIMEOUT (TIMEOUT!=0), the block SHALL deassert all bus valids/readies, go to RESP with resp_err=1 and resp_rdata=0.
REQ-019 A readData_valid or writeResp_valid arriving outside RDATA/WRESP SHALL be ignored (ready low).
REQ-020 Address outputs SHALL carry the captured full 32-bit addr; unused channels SHALL drive address/data/strb 0.

Reset
REQ-021 On rst SHALL go to IDLE immediately, mid-transaction included.
REQ-022 Reset values SHALL be: req_ready=1 after release; all *_valid, *_ready outputs, resp_err, resp_valid=0; resp_rdata and captured registers=0; timeout counter=0.

Verification
REQ-023 Read: SRAM line 0x0010 preloaded with 0x00112233_44556677_8899AABB_CCDDEEFF; read 0x10 -> resp_rdata equals the preloaded line, resp_err=0.
REQ-024 Masked write: addr 0x20, wdata all 0xA5, wstrb 0x00FF, then read 0x20 -> low 8 bytes 0xA5, high 8 bytes unchanged.
REQ-025 Skewed handshake: writeData_ready 3 cycles after writeAddr_ready -> exactly one AW and one W handshake, WRESP entered only after both.
REQ-026 Misaligned: addr 0x24 -> resp_err=1 within 2 cycles, no bus valid asserted.
REQ-027 Timeout: TIMEOUT=8, readAddr_ready tied 0 -> resp_err=1 with resp_valid 9 cycles after acceptance; resp_ready held 0 for 5 cycles -> response stable.
REQ-028 rst pulsed in WSEND -> all valids 0 immediately; next read completes correctly.
